round_banner_renderer: RTL and testbench

Per-pixel front end for the round-number banner sprites. It takes the VGA beam position and a round-start pulse, and generates the sprite ROM select and address. It aligns the ROM's palette index with a pixel-on flag, so the downstream RoundN palette lookup and colour mux see a coherent, fixed-latency stream. A frame-counted FSM shows the banner for a fixed time after each round start, blinking during that time.

---
 rtl/round_banner_pkg.sv | 23 ++
 rtl/round_banner_renderer_if.sv | 30 +++
 rtl/banner_frame_fsm.sv | 87 ++++++++
 rtl/round_banner_renderer.sv | 111 +++++++++++
 tb/tb_round_banner_renderer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/round_banner_pkg.sv
// Shared definitions for the round-number banner renderer.
//   banner_state_e : FSM encoding (IDLE / SHOW)
//   KEY_INDEX      : palette index treated as transparent
//   MAX_ROUND      : highest round number with a banner sprite
//   PIPE_LATENCY   : DrawX/DrawY -> pal_index/pixel_on latency; the colour
//                    mux delays its other layers by this many cycles
package round_banner_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } banner_state_e;

  localparam logic [3:0] KEY_INDEX    = 4'd0;
  localparam logic [3:0] MAX_ROUND    = 4'd9;
  localparam int         PIPE_LATENCY = 3;

  // A round number has a banner only in 1..MAX_ROUND.
  function automatic logic round_valid(input logic [3:0] n);
    return (n >= 4'd1) && (n <= MAX_ROUND);
  endfunction

endpackage

// File: rtl/round_banner_renderer_if.sv
// Pixel-side bundle of the banner renderer.
//   slave  : the renderer (beam/sync/round inputs, ROM data in; ROM select,
//            ROM address, palette index, pixel flag and busy out)
//   master : the driving side (video timing, game logic, sprite ROM)
interface round_banner_renderer_if #(
  parameter int ADDR_W = 11
);
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              blank;
  logic              vs;
  logic              round_start;
  logic [3:0]        round_num;
  logic [3:0]        rom_sel;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_q;
  logic [3:0]        pal_index;
  logic              pixel_on;
  logic              busy;

  modport slave (
    input  DrawX, DrawY, blank, vs, round_start, round_num, rom_q,
    output rom_sel, rom_addr, pal_index, pixel_on, busy
  );

  modport master (
    output DrawX, DrawY, blank, vs, round_start, round_num, rom_q,
    input  rom_sel, rom_addr, pal_index, pixel_on, busy
  );
endinterface

// File: rtl/banner_frame_fsm.sv
// Frame-counted show/blink controller for the round banner.
// Ports:
//   Clk, Reset_n : pixel clock, async active-low reset
//   vs           : vertical sync (active low); its falling edge is the frame tick
//   round_start  : one-cycle pulse, round_num sampled with it
//   rom_sel      : latched round number (selects RoundN ROM/palette)
//   busy         : banner active (SHOW)
//   vis_frame    : banner visible for the current frame, changes only on tick
module banner_frame_fsm #(
  parameter int SHOW_FRAMES  = 180,
  parameter int BLINK_FRAMES = 15
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       vs,
  input  logic       round_start,
  input  logic [3:0] round_num,
  output logic [3:0] rom_sel,
  output logic       busy,
  output logic       vis_frame
);
  import round_banner_pkg::*;

  localparam int FW = $clog2(SHOW_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_SHOW = SHOW;

  logic [0:0]    state_r;
  logic          vs_d_r;
  logic [FW-1:0] frame_cnt_r;
  logic [BW-1:0] blink_cnt_r;
  logic          phase_r;
  logic          vis_frame_r;
  logic [3:0]    rom_sel_r;
  logic          tick_s;
  logic          start_s;

  assign tick_s  = vs_d_r & ~vs;
  assign start_s = round_start & round_valid(round_num);

  // Sync edge register, visibility snapshot, and the show/blink FSM.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= ST_IDLE;
      vs_d_r      <= 1'b0;
      frame_cnt_r <= '0;
      blink_cnt_r <= '0;
      phase_r     <= 1'b0;
      vis_frame_r <= 1'b0;
      rom_sel_r   <= 4'd0;
    end else begin
      vs_d_r <= vs;

      // Snapshot uses pre-update state so a mid-frame change waits a frame.
      if (tick_s) begin
        vis_frame_r <= (state_r == ST_SHOW) && phase_r;
      end

      // A valid start (also a retrigger) wins over a same-cycle tick.
      if (start_s) begin
        state_r     <= ST_SHOW;
        rom_sel_r   <= round_num;
        frame_cnt_r <= FW'(SHOW_FRAMES);
        blink_cnt_r <= '0;
        phase_r     <= 1'b1;
      end else if ((state_r == ST_SHOW) && tick_s) begin
        if (frame_cnt_r == FW'(1)) begin
          state_r <= ST_IDLE;
        end
        frame_cnt_r <= frame_cnt_r - FW'(1);
        if (blink_cnt_r == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt_r <= '0;
          phase_r     <= ~phase_r;
        end else begin
          blink_cnt_r <= blink_cnt_r + BW'(1);
        end
      end
    end
  end

  assign rom_sel   = rom_sel_r;
  assign busy      = (state_r == ST_SHOW);
  assign vis_frame = vis_frame_r;

endmodule

// File: rtl/round_banner_renderer.sv
// Round banner pixel front end: box test and sprite ROM addressing, then
// alignment of the ROM's palette index with a pixel-on flag.
// DrawX/DrawY/blank -> pal_index/pixel_on takes exactly PIPE_LATENCY cycles.
// Ports:
//   Clk, Reset_n : pixel clock, async active-low reset
//   bus (slave)  : DrawX, DrawY, blank, vs, round_start, round_num, rom_q in;
//                  rom_sel, rom_addr, pal_index, pixel_on, busy out
module round_banner_renderer #(
  parameter int         SPR_W        = 64,
  parameter int         SPR_H        = 32,
  parameter int         SCALE_SHIFT  = 1,
  parameter int         POS_X        = 256,
  parameter int         POS_Y        = 64,
  parameter int         SHOW_FRAMES  = 180,
  parameter int         BLINK_FRAMES = 15,
  parameter logic [3:0] KEY_INDEX    = round_banner_pkg::KEY_INDEX,
  parameter int         ADDR_W       = 11
) (
  input logic                    Clk,
  input logic                    Reset_n,
  round_banner_renderer_if.slave bus
);
  import round_banner_pkg::*;

  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);

  // Box bounds at 11 bits so POS + size never wraps.
  localparam logic [10:0] X_LO = 11'(POS_X);
  localparam logic [10:0] X_HI = 11'(POS_X + (SPR_W << SCALE_SHIFT));
  localparam logic [10:0] Y_LO = 11'(POS_Y);
  localparam logic [10:0] Y_HI = 11'(POS_Y + (SPR_H << SCALE_SHIFT));

  logic [10:0]       x11_s;
  logic [10:0]       y11_s;
  logic [10:0]       x_rel_s;
  logic [10:0]       y_rel_s;
  logic [XW-1:0]     xs_s;
  logic [YW-1:0]     ys_s;
  logic [ADDR_W-1:0] addr_s;
  logic              in_box_s;
  logic              hit_s;
  logic              vis_frame_s;
  logic [3:0]        rom_sel_s;
  logic              busy_s;

  logic              in_box_r;
  logic              vis_d1_r;
  logic [ADDR_W-1:0] rom_addr_r;
  logic              in_box_d2_r;
  logic              vis_d2_r;
  logic [3:0]        pal_index_r;
  logic              pixel_on_r;

  banner_frame_fsm #(
    .SHOW_FRAMES  (SHOW_FRAMES),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_fsm (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .vs          (bus.vs),
    .round_start (bus.round_start),
    .round_num   (bus.round_num),
    .rom_sel     (rom_sel_s),
    .busy        (busy_s),
    .vis_frame   (vis_frame_s)
  );

  assign x11_s   = {1'b0, bus.DrawX};
  assign y11_s   = {1'b0, bus.DrawY};
  assign x_rel_s = x11_s - X_LO;
  assign y_rel_s = y11_s - Y_LO;
  assign xs_s    = XW'(x_rel_s >> SCALE_SHIFT);
  assign ys_s    = YW'(y_rel_s >> SCALE_SHIFT);
  // SPR_W is a power of two, so row*SPR_W + col is a concatenation.
  assign addr_s  = ADDR_W'({ys_s, xs_s});

  assign in_box_s = bus.blank &&
                    (x11_s >= X_LO) && (x11_s < X_HI) &&
                    (y11_s >= Y_LO) && (y11_s < Y_HI);

  assign hit_s = in_box_d2_r && vis_d2_r;

  // S1 address/box, S2 alignment with ROM latency, S3 palette output.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      in_box_r    <= 1'b0;
      vis_d1_r    <= 1'b0;
      rom_addr_r  <= '0;
      in_box_d2_r <= 1'b0;
      vis_d2_r    <= 1'b0;
      pal_index_r <= 4'd0;
      pixel_on_r  <= 1'b0;
    end else begin
      in_box_r    <= in_box_s;
      vis_d1_r    <= vis_frame_s;
      rom_addr_r  <= in_box_s ? addr_s : '0;
      in_box_d2_r <= in_box_r;
      vis_d2_r    <= vis_d1_r;
      pal_index_r <= hit_s ? bus.rom_q : KEY_INDEX;
      pixel_on_r  <= hit_s && (bus.rom_q != KEY_INDEX);
    end
  end

  assign bus.rom_sel   = rom_sel_s;
  assign bus.busy      = busy_s;
  assign bus.rom_addr  = rom_addr_r;
  assign bus.pal_index = pal_index_r;
  assign bus.pixel_on  = pixel_on_r;

endmodule

// File: tb/tb_round_banner_renderer.sv
module tb_round_banner_renderer;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank;
    logic [10:0] exp_addr;
    logic [3:0]  exp_pal;
    logic        exp_on;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  vec_t vecs [11];

  round_banner_renderer_if #(.ADDR_W(11)) bus ();

  round_banner_renderer dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench sprite ROM: synchronous read, data = addr[3:0] ^ sel.
  function automatic logic [3:0] rom_data(input logic [3:0] sel, input logic [10:0] a);
    return a[3:0] ^ sel;
  endfunction

  initial bus.rom_q = 4'd0;
  always @(posedge clk) bus.rom_q <= rom_data(bus.rom_sel, bus.rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    bus.vs = 1'b0;
    cyc(1);
    bus.vs = 1'b1;
    cyc(1);
  endtask

  task automatic start(input logic [3:0] n, input logic with_tick);
    bus.round_start = 1'b1;
    bus.round_num   = n;
    if (with_tick) bus.vs = 1'b0;
    cyc(1);
    bus.round_start = 1'b0;
    bus.vs          = 1'b1;
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic b);
    bus.DrawX = x;
    bus.DrawY = y;
    bus.blank = b;
    cyc(3);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rom_sel"},   32'(bus.rom_sel),   32'd0);
    check({tag, "_rom_addr"},  32'(bus.rom_addr),  32'd0);
    check({tag, "_pal_index"}, 32'(bus.pal_index), 32'd0);
    check({tag, "_pixel_on"},  32'(bus.pixel_on),  32'd0);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
  endtask

  initial begin
    logic exp_on;
    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{10'd256,  10'd64,  1'b1, 11'd0,    4'd9, 1'b1};
    vecs[1]  = '{10'd259,  10'd67,  1'b1, 11'd65,   4'd8, 1'b1};
    vecs[2]  = '{10'd255,  10'd64,  1'b1, 11'd0,    4'd0, 1'b0};
    vecs[3]  = '{10'd384,  10'd64,  1'b1, 11'd0,    4'd0, 1'b0};
    vecs[4]  = '{10'd383,  10'd127, 1'b1, 11'd2047, 4'd6, 1'b1};
    vecs[5]  = '{10'd256,  10'd63,  1'b1, 11'd0,    4'd0, 1'b0};
    vecs[6]  = '{10'd256,  10'd128, 1'b1, 11'd0,    4'd0, 1'b0};
    vecs[7]  = '{10'd300,  10'd100, 1'b0, 11'd0,    4'd0, 1'b0};
    vecs[8]  = '{10'd274,  10'd64,  1'b1, 11'd9,    4'd0, 1'b0};
    vecs[9]  = '{10'd272,  10'd64,  1'b1, 11'd8,    4'd1, 1'b1};
    vecs[10] = '{10'd1023, 10'd1023,1'b1, 11'd0,    4'd0, 1'b0};

    rst_n           = 1'b0;
    bus.DrawX       = 10'd256;
    bus.DrawY       = 10'd64;
    bus.blank       = 1'b1;
    bus.vs          = 1'b1;
    bus.round_start = 1'b0;
    bus.round_num   = 4'd0;
    cyc(3);
    check_zero("reset");
    rst_n = 1'b1;
    cyc(2);

    // Out-of-range round numbers are ignored.
    start(4'd0, 1'b0);
    cyc(1);
    check("rn0_busy", 32'(bus.busy), 32'd0);
    start(4'd12, 1'b0);
    cyc(1);
    check("rn12_busy", 32'(bus.busy), 32'd0);
    check("rn12_rom_sel", 32'(bus.rom_sel), 32'd0);

    // Mid-frame start: not visible until the next tick.
    start(4'd9, 1'b0);
    check("start_busy", 32'(bus.busy), 32'd1);
    check("start_rom_sel", 32'(bus.rom_sel), 32'd9);
    pix(10'd256, 10'd64, 1'b1);
    check("midframe_pixel_on", 32'(bus.pixel_on), 32'd0);
    check("midframe_pal", 32'(bus.pal_index), 32'd0);
    pix(10'd259, 10'd67, 1'b1);
    check("midframe2_pixel_on", 32'(bus.pixel_on), 32'd0);
    check("midframe_addr", 32'(bus.rom_addr), 32'd65);
    tick();

    for (int i = 0; i < 11; i++) begin
      pix(vecs[i].x, vecs[i].y, vecs[i].blank);
      check($sformatf("vec%0d_addr", i), 32'(bus.rom_addr), 32'(vecs[i].exp_addr));
      check($sformatf("vec%0d_pal", i), 32'(bus.pal_index), 32'(vecs[i].exp_pal));
      check($sformatf("vec%0d_on", i), 32'(bus.pixel_on), 32'(vecs[i].exp_on));
    end

    // Blink: retrigger, then 15 visible / 15 hidden, banner ends at tick 180.
    start(4'd9, 1'b0);
    for (int k = 1; k <= 182; k++) begin
      tick();
      pix(10'd256, 10'd64, 1'b1);
      exp_on = (k <= 180) && ((((k - 1) / 15) % 2) == 0);
      check($sformatf("blink%0d_on", k), 32'(bus.pixel_on), 32'(exp_on));
      check($sformatf("blink%0d_busy", k), 32'(bus.busy), (k < 180) ? 32'd1 : 32'd0);
    end
    check("end_pal", 32'(bus.pal_index), 32'd0);

    // Retrigger with round 3 in the same cycle as a tick, in the hidden phase.
    start(4'd9, 1'b0);
    repeat (20) tick();
    start(4'd3, 1'b1);
    cyc(1);
    check("retrig_rom_sel", 32'(bus.rom_sel), 32'd3);
    check("retrig_busy", 32'(bus.busy), 32'd1);
    pix(10'd256, 10'd64, 1'b1);
    check("retrig_hidden_on", 32'(bus.pixel_on), 32'd0);
    tick();
    pix(10'd256, 10'd64, 1'b1);
    check("retrig_vis_on", 32'(bus.pixel_on), 32'd1);
    check("retrig_vis_pal", 32'(bus.pal_index), 32'd3);
    repeat (178) tick();
    check("retrig_179_busy", 32'(bus.busy), 32'd1);
    tick();
    check("retrig_180_busy", 32'(bus.busy), 32'd0);

    // Async reset mid-line while the banner is drawing.
    start(4'd9, 1'b0);
    tick();
    pix(10'd258, 10'd64, 1'b1);
    check("prereset_on", 32'(bus.pixel_on), 32'd1);
    check("prereset_addr", 32'(bus.rom_addr), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    for (int f = 0; f < 2; f++) begin
      for (int j = 0; j < 4; j++) begin
        pix(10'(256 + 30 * j), 10'(64 + 15 * j), 1'b1);
        check($sformatf("postreset_f%0d_p%0d_on", f, j), 32'(bus.pixel_on), 32'd0);
      end
      tick();
    end
    check("postreset_busy", 32'(bus.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
